// File: rtl/transmit_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set selector (data path only, no autoneg).
// Chooses the ordered set handed to the code-group generator each time the
// current one completes, delays TXD by one cycle so it lines up with /D/,
// and keeps saturating counts of terminated packets and error code-groups.
module transmit_ordered_set #(
  parameter int CNT_W = 16
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic             TX_EN,
  input  logic             TX_ER,
  input  logic [7:0]       TXD,
  input  logic             TX_OSET_indicate,
  input  logic             tx_even,
  output logic [6:0]       tx_o_set,
  output logic [7:0]       TXD_out,
  output logic             transmitting,
  output logic [CNT_W-1:0] tx_pkt_count,
  output logic [CNT_W-1:0] tx_err_count
);

  // Ordered-set codes understood by the code-group generator (tx_os_* values).
  localparam logic [6:0] TX_OS_I = 7'b0000001;
  localparam logic [6:0] TX_OS_R = 7'b0000010;
  localparam logic [6:0] TX_OS_S = 7'b0000100;
  localparam logic [6:0] TX_OS_T = 7'b0001000;
  localparam logic [6:0] TX_OS_V = 7'b0010000;
  localparam logic [6:0] TX_OS_D = 7'b0100000;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    XMIT_DATA           = 3'd0,
    START_OF_PACKET     = 3'd1,
    TX_DATA             = 3'd2,
    TX_DATA_ERROR       = 3'd3,
    END_OF_PACKET_NOEXT = 3'd4,
    EPD2_NOEXT          = 3'd5,
    EPD3                = 3'd6
  } state_t;

  state_t state;
  state_t next_state;
  logic   pkt_inc;
  logic   err_inc;

  // State register; a reset mid-frame drops straight back to idle with no /T/R/ tail.
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state <= XMIT_DATA;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; nothing moves until the code-group stage finishes the
  // current ordered set. The packet decode is shared by /S/, /D/ and /V/, and
  // the counter strobes mark entries into /T/ and /V/.
  always_comb begin
    next_state = state;
    pkt_inc    = 1'b0;
    err_inc    = 1'b0;
    if (TX_OSET_indicate) begin
      case (state)
        XMIT_DATA: begin
          if (TX_EN && !TX_ER) begin
            next_state = START_OF_PACKET;
          end
        end
        START_OF_PACKET, TX_DATA, TX_DATA_ERROR: begin
          if (!TX_EN) begin
            next_state = END_OF_PACKET_NOEXT;
            pkt_inc    = 1'b1;
          end else if (TX_ER) begin
            next_state = TX_DATA_ERROR;
            err_inc    = 1'b1;
          end else begin
            next_state = TX_DATA;
          end
        end
        END_OF_PACKET_NOEXT: next_state = EPD2_NOEXT;
        EPD2_NOEXT:          next_state = tx_even ? XMIT_DATA : EPD3;
        EPD3:                next_state = XMIT_DATA;
        default:             next_state = XMIT_DATA;
      endcase
    end
  end

  // Moore decode of the ordered set and the transmitting flag from the registered state.
  always_comb begin
    tx_o_set     = TX_OS_I;
    transmitting = 1'b0;
    case (state)
      START_OF_PACKET: begin
        tx_o_set     = TX_OS_S;
        transmitting = 1'b1;
      end
      TX_DATA: begin
        tx_o_set     = TX_OS_D;
        transmitting = 1'b1;
      end
      TX_DATA_ERROR: begin
        tx_o_set     = TX_OS_V;
        transmitting = 1'b1;
      end
      END_OF_PACKET_NOEXT: tx_o_set = TX_OS_T;
      EPD2_NOEXT, EPD3:    tx_o_set = TX_OS_R;
      default:             tx_o_set = TX_OS_I;
    endcase
  end

  // One-cycle TXD delay so the byte sampled with a transition rides on the following /D/.
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      TXD_out <= 8'h00;
    end else begin
      TXD_out <= TXD;
    end
  end

  // Saturating packet and error counters, updated on the same edge as the state entry.
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      tx_pkt_count <= '0;
      tx_err_count <= '0;
    end else begin
      if (pkt_inc && (tx_pkt_count != CNT_MAX)) begin
        tx_pkt_count <= tx_pkt_count + CNT_ONE;
      end
      if (err_inc && (tx_err_count != CNT_MAX)) begin
        tx_err_count <= tx_err_count + CNT_ONE;
      end
    end
  end

endmodule
